// File: rtl/evt_pkg.sv
// Shared types and width helpers for the single-cycle event interface
// (evt_generator producer side, evt_counter consumer side).
package evt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } evt_gen_state_t;

  function automatic int count_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

  function automatic int period_width(input int max_period);
    return $clog2(max_period + 1);
  endfunction

endpackage

// File: rtl/period_timer.sv
// Loadable down-counter that parks at zero; zero_out flags the parked state.
module period_timer #(
  parameter int PW = 11
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          load,
  input  logic [PW-1:0] value,
  output logic          zero_out
);

  logic [PW-1:0] count;

  // load wins; otherwise count down and hold at zero so it never wraps
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - PW'(1);
    end else begin
      count <= count;
    end
  end

  assign zero_out = (count == '0);

endmodule

// File: rtl/evt_generator.sv
// Burst event generator: emits count one-cycle pulses on evt_out spaced period
// cycles apart, with completion strobe and abort.
module evt_generator
  import evt_pkg::*;
#(
  parameter  int MAX_COUNT  = 6,
  parameter  int MAX_PERIOD = 1024,
  localparam int CW         = count_width(MAX_COUNT),
  localparam int PW         = period_width(MAX_PERIOD)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          start_valid_in,
  output logic          start_ready_out,
  input  logic [CW-1:0] count_in,
  input  logic [PW-1:0] period_in,
  input  logic          abort_in,
  output logic          evt_out,
  output logic [CW-1:0] sent_out,
  output logic          busy_out,
  output logic          done_out
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_COUNT);

  evt_gen_state_t state, state_nxt;
  logic [CW-1:0]  count, sent, count_clamped;
  logic [PW-1:0]  period, period_eff, timer_value;
  logic           evt, evt_nxt, done, done_nxt;
  logic           accept, last_pulse, timer_load, timer_zero;

  assign start_ready_out = (state == IDLE) && !abort_in;
  assign accept          = start_valid_in && start_ready_out;
  assign count_clamped   = (count_in > MAX_CNT) ? MAX_CNT : count_in;
  assign period_eff      = (period_in == '0) ? PW'(1) : period_in;
  // sent lags evt by a cycle, so the pulse on the wire now is number sent+1
  assign last_pulse      = ((sent + CW'(1)) == count);
  // the GAP state itself spends one cycle and the reload cycle another
  assign timer_value     = period - PW'(2);

  // next-state and next-output decode
  always_comb begin
    state_nxt  = state;
    evt_nxt    = 1'b0;
    done_nxt   = 1'b0;
    timer_load = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (count_clamped != '0) begin
            state_nxt = PULSE;
            evt_nxt   = 1'b1;
          end else begin
            done_nxt  = 1'b1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      PULSE: begin
        if (abort_in) begin
          state_nxt = IDLE;
        end else if (last_pulse) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else if (period == PW'(1)) begin
          state_nxt = PULSE;
          evt_nxt   = 1'b1;
        end else begin
          state_nxt  = GAP;
          timer_load = 1'b1;
        end
      end
      GAP: begin
        if (abort_in) begin
          state_nxt = IDLE;
        end else if (timer_zero) begin
          state_nxt = PULSE;
          evt_nxt   = 1'b1;
        end else begin
          state_nxt = GAP;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // state, burst parameters and output registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state  <= IDLE;
      count  <= '0;
      period <= PW'(1);
      sent   <= '0;
      evt    <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      evt   <= evt_nxt;
      done  <= done_nxt;
      if (accept) begin
        count  <= count_clamped;
        period <= period_eff;
        sent   <= '0;
      end else if (evt) begin
        sent   <= sent + CW'(1);
      end else begin
        sent   <= sent;
      end
    end
  end

  period_timer #(
    .PW (PW)
  ) u_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load     (timer_load),
    .value    (timer_value),
    .zero_out (timer_zero)
  );

  assign evt_out  = evt;
  assign sent_out = sent;
  assign done_out = done;
  assign busy_out = (state != IDLE);

endmodule

// File: tb/tb_evt_generator.sv
// Self-checking bench for evt_generator: directed scenarios then random bursts,
// compared every cycle against a schedule-based reference model.
module tb_evt_generator;

  localparam int MAX_COUNT  = 6;
  localparam int MAX_PERIOD = 1024;
  localparam int CW         = $clog2(MAX_COUNT + 1);
  localparam int PW         = $clog2(MAX_PERIOD + 1);
  localparam int NEVER      = 32'h3fff_ffff;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          start_valid_in = 1'b0;
  logic          abort_in = 1'b0;
  logic [CW-1:0] count_in = '0;
  logic [PW-1:0] period_in = '0;
  logic          start_ready_out, evt_out, busy_out, done_out;
  logic [CW-1:0] sent_out;

  always #5 clk_in = ~clk_in;

  evt_generator #(
    .MAX_COUNT  (MAX_COUNT),
    .MAX_PERIOD (MAX_PERIOD)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .start_valid_in  (start_valid_in),
    .start_ready_out (start_ready_out),
    .count_in        (count_in),
    .period_in       (period_in),
    .abort_in        (abort_in),
    .evt_out         (evt_out),
    .sent_out        (sent_out),
    .busy_out        (busy_out),
    .done_out        (done_out)
  );

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Reference model: the latest burst is described by its accept cycle,
  // clamped length/spacing and an optional abort cycle.
  bit m_have    = 1'b0;
  bit m_done_ok = 1'b0;
  int m_a = 0, m_n = 0, m_p = 1, m_abort = NEVER;

  function automatic int pulse_cycle(int k);
    return m_a + 1 + k * m_p;
  endfunction

  function automatic bit m_evt(int c);
    if (!m_have) return 1'b0;
    for (int k = 0; k < m_n; k++)
      if (c == pulse_cycle(k) && c <= m_abort) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_sent(int c);
    int s = 0;
    if (!m_have) return 0;
    for (int k = 0; k < m_n; k++)
      if (pulse_cycle(k) < c && pulse_cycle(k) <= m_abort) s++;
    return s;
  endfunction

  function automatic bit m_busy(int c);
    int last;
    if (!m_have || m_n == 0) return 1'b0;
    last = pulse_cycle(m_n - 1);
    if (m_abort < last) last = m_abort;
    return (c >= m_a + 1) && (c <= last);
  endfunction

  function automatic bit m_done(int c);
    if (!m_have || !m_done_ok) return 1'b0;
    if (m_n == 0) return c == m_a + 1;
    return c == pulse_cycle(m_n - 1) + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs(input bit ab);
    chk("evt_out",   32'(evt_out),         32'(m_evt(cyc)));
    chk("sent_out",  32'(sent_out),        m_sent(cyc));
    chk("busy_out",  32'(busy_out),        32'(m_busy(cyc)));
    chk("done_out",  32'(done_out),        32'(m_done(cyc)));
    chk("ready_out", 32'(start_ready_out), 32'(!m_busy(cyc) && !ab));
  endtask

  // One clock cycle: drive inputs, check outputs, then advance the model.
  task automatic cycle(input bit v, input int cnt, input int per, input bit ab, output bit acc);
    @(negedge clk_in);
    start_valid_in = v;
    count_in       = CW'(cnt);
    period_in      = PW'(per);
    abort_in       = ab;
    #1;
    check_outputs(ab);
    acc = 1'b0;
    if (ab && m_busy(cyc)) begin
      m_abort   = cyc;
      m_done_ok = 1'b0;
    end else if (v && !ab && !m_busy(cyc) && !rst_in) begin
      acc       = 1'b1;
      m_have    = 1'b1;
      m_done_ok = 1'b1;
      m_a       = cyc;
      m_n       = (cnt > MAX_COUNT) ? MAX_COUNT : cnt;
      m_p       = (per == 0) ? 1 : per;
      m_abort   = NEVER;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, acc);
  endtask

  initial begin
    bit acc;
    bit pend;
    int pc, pp;

    // reset held: outputs quiet, ready still high
    idle(2);
    @(negedge clk_in);
    rst_in = 1'b0;
    idle(4);

    // 3 pulses every 4 cycles
    cycle(1'b1, 3, 4, 1'b0, acc);
    idle(12);

    // 6 back-to-back pulses
    cycle(1'b1, 6, 1, 1'b0, acc);
    idle(9);

    // empty burst: done next cycle, never busy
    cycle(1'b1, 0, 5, 1'b0, acc);
    idle(3);

    // abort during the gap after the 2nd pulse
    cycle(1'b1, 5, 3, 1'b0, acc);
    idle(4);
    cycle(1'b0, 0, 0, 1'b1, acc);
    idle(8);

    // clamped count and period, next request held valid into the done cycle
    cycle(1'b1, 7, 0, 1'b0, acc);
    for (int i = 0; i < 7; i++) cycle(1'b1, 2, 2, 1'b0, acc);
    chk("accept_in_done_cycle", 32'(acc), 1);
    idle(6);

    // asynchronous reset in the middle of a gap
    cycle(1'b1, 3, 6, 1'b0, acc);
    idle(3);
    @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    #1;
    m_have = 1'b0;
    check_outputs(1'b0);
    idle(2);
    @(negedge clk_in);
    rst_in = 1'b0;
    cycle(1'b1, 2, 3, 1'b0, acc);
    idle(8);

    // random bursts with requests held until accepted and sporadic aborts
    pend = 1'b0;
    pc   = 0;
    pp   = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend && $urandom_range(0, 3) == 0) begin
        pend = 1'b1;
        pc   = $urandom_range(0, 7);
        pp   = $urandom_range(0, 5);
      end
      cycle(pend, pc, pp, ($urandom_range(0, 15) == 0), acc);
      if (acc) pend = 1'b0;
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
